// File: rtl/alu_seq.sv
// Multi-cycle W-bit ALU with valid/ready handshakes, iterative shift/rotate,
// a shift-add multiplier and a {C,N,Z,V} status register written on completion.
module alu_seq #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [3:0]   op,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] res,
  output logic [W-1:0] res_hi,
  output logic [3:0]   flags,
  output logic         busy
);
  localparam int SW = $clog2(W);

  localparam logic [3:0] OP_NOP   = 4'd0;
  localparam logic [3:0] OP_ADD   = 4'd1;
  localparam logic [3:0] OP_ADC   = 4'd2;
  localparam logic [3:0] OP_SUB   = 4'd3;
  localparam logic [3:0] OP_SBC   = 4'd4;
  localparam logic [3:0] OP_INC   = 4'd5;
  localparam logic [3:0] OP_DEC   = 4'd6;
  localparam logic [3:0] OP_AND   = 4'd7;
  localparam logic [3:0] OP_OR    = 4'd8;
  localparam logic [3:0] OP_XOR   = 4'd9;
  localparam logic [3:0] OP_NOT   = 4'd10;
  localparam logic [3:0] OP_SHL   = 4'd11;
  localparam logic [3:0] OP_ROR   = 4'd12;
  localparam logic [3:0] OP_MUL   = 4'd13;
  localparam logic [3:0] OP_PASSB = 4'd14;
  localparam logic [3:0] OP_CMP   = 4'd15;

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

  state_t       state;
  logic [3:0]   op_reg;
  logic [W-1:0] a_reg;   // operand, also the shift/rotate working value
  logic [W-1:0] b_reg;   // operand, also the multiplier / low product half
  logic [W-1:0] hi_reg;  // multiplier high accumulator
  logic [SW:0]  cnt_reg;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);

  // Shared W-bit adder for the arithmetic opcodes
  logic [W-1:0] add_b;
  logic         add_cin;
  logic [W:0]   sum;
  logic         ovf;

  always_comb begin
    add_b   = b_reg;
    add_cin = 1'b0;
    case (op_reg)
      OP_ADC:         add_cin = flags[3];
      OP_SUB, OP_CMP: begin add_b = ~b_reg; add_cin = 1'b1; end
      OP_SBC:         begin add_b = ~b_reg; add_cin = flags[3]; end
      OP_INC:         begin add_b = '0;     add_cin = 1'b1; end
      OP_DEC:         add_b = '1;
      default:        ;
    endcase
  end

  assign sum = {1'b0, a_reg} + {1'b0, add_b} + {{W{1'b0}}, add_cin};
  assign ovf = (a_reg[W-1] == add_b[W-1]) && (sum[W-1] != a_reg[W-1]);

  logic [W-1:0] shl_next, ror_next;
  logic [W:0]   mul_sum;
  logic [W-1:0] mul_hi_next, mul_lo_next;

  assign shl_next    = {a_reg[W-2:0], 1'b0};
  assign ror_next    = {a_reg[0], a_reg[W-1:1]};
  assign mul_sum     = {1'b0, hi_reg} + (b_reg[0] ? {1'b0, a_reg} : {(W+1){1'b0}});
  assign mul_hi_next = mul_sum[W:1];
  assign mul_lo_next = {mul_sum[0], b_reg[W-1:1]};

  // Completion value of the current EXEC cycle
  logic         fin_done;
  logic [W-1:0] fin_res, fin_hi, nz_src;
  logic         fin_c, fin_v, fin_upd;
  logic [3:0]   fin_flags;

  always_comb begin
    fin_done = 1'b1;
    fin_res  = '0;
    fin_hi   = '0;
    fin_c    = flags[3];
    fin_v    = 1'b0;
    fin_upd  = 1'b1;
    nz_src   = '0;
    case (op_reg)
      OP_NOP: fin_upd = 1'b0;
      OP_ADD, OP_ADC, OP_SUB, OP_SBC, OP_INC, OP_DEC: begin
        fin_res = sum[W-1:0];
        fin_c   = sum[W];
        fin_v   = ovf;
      end
      OP_CMP: begin
        fin_res = a_reg;
        fin_c   = sum[W];
        fin_v   = ovf;
      end
      OP_AND:   fin_res = a_reg & b_reg;
      OP_OR:    fin_res = a_reg | b_reg;
      OP_XOR:   fin_res = a_reg ^ b_reg;
      OP_NOT:   fin_res = ~a_reg;
      OP_PASSB: fin_res = b_reg;
      OP_SHL: begin
        fin_done = (cnt_reg <= (SW+1)'(1));
        if (cnt_reg == '0) begin
          fin_res = a_reg;
        end else begin
          fin_res = shl_next;
          fin_c   = a_reg[W-1];
        end
      end
      OP_ROR: begin
        fin_done = (cnt_reg <= (SW+1)'(1));
        if (cnt_reg == '0) begin
          fin_res = a_reg;
        end else begin
          fin_res = ror_next;
          fin_c   = a_reg[0];
        end
      end
      OP_MUL: begin
        fin_done = (cnt_reg == (SW+1)'(1));
        fin_res  = mul_lo_next;
        fin_hi   = mul_hi_next;
        fin_c    = (mul_hi_next != '0);
        fin_v    = (mul_hi_next != '0);
      end
      default: ;
    endcase
    // CMP reports the flags of the subtraction while passing a through
    nz_src    = (op_reg == OP_CMP) ? sum[W-1:0] : fin_res;
    fin_flags = fin_upd ? {fin_c, nz_src[W-1], (nz_src == '0), fin_v} : flags;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      op_reg  <= OP_NOP;
      a_reg   <= '0;
      b_reg   <= '0;
      hi_reg  <= '0;
      cnt_reg <= '0;
      res     <= '0;
      res_hi  <= '0;
      flags   <= 4'b0000;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            op_reg  <= op;
            a_reg   <= a;
            b_reg   <= b;
            hi_reg  <= '0;
            cnt_reg <= (op == OP_MUL) ? (SW+1)'(W) : {1'b0, b[SW-1:0]};
            state   <= EXEC;
          end
        end
        EXEC: begin
          if (fin_done) begin
            res    <= fin_res;
            res_hi <= fin_hi;
            flags  <= fin_flags;
            state  <= DONE;
          end else begin
            cnt_reg <= cnt_reg - (SW+1)'(1);
            if (op_reg == OP_SHL) a_reg <= shl_next;
            if (op_reg == OP_ROR) a_reg <= ror_next;
            if (op_reg == OP_MUL) begin
              hi_reg <= mul_hi_next;
              b_reg  <= mul_lo_next;
            end
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_seq.sv
// Directed, table-driven bench for alu_seq at W=8 plus hand-written
// sequences for hold/backpressure, mid-operation reset and back-to-back issue.
module tb_alu_seq;
  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid, in_ready, out_valid, out_ready, busy;
  logic [3:0] op, flags;
  logic [7:0] a, b, res, res_hi;

  int checks = 0;
  int errors = 0;

  alu_seq #(.W(8)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .res(res), .res_hi(res_hi), .flags(flags), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] op;
    logic [7:0] a, b, exp_res, exp_hi;
    logic [3:0] exp_flags;
    int         exp_lat;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Issue one op from IDLE, measure latency, consume the result.
  task automatic run_op(input logic [3:0] o, input logic [7:0] ia, input logic [7:0] ib,
                        output logic [7:0] r, output logic [7:0] rh,
                        output logic [3:0] f, output int lat);
    op = o; a = ia; b = ib; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
    r = res; rh = res_hi; f = flags;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  vec_t vecs[$];
  logic [7:0] r, rh;
  logic [3:0] f;
  int lat;

  initial begin
    // op a b res hi flags{C,N,Z,V} latency
    vecs.push_back('{4'd3,  8'h05, 8'h05, 8'h00, 8'h00, 4'b1010, 1});
    vecs.push_back('{4'd4,  8'h10, 8'h01, 8'h0F, 8'h00, 4'b1000, 1});
    vecs.push_back('{4'd1,  8'h01, 8'h01, 8'h02, 8'h00, 4'b0000, 1});
    vecs.push_back('{4'd4,  8'h10, 8'h01, 8'h0E, 8'h00, 4'b1000, 1});
    vecs.push_back('{4'd13, 8'hFF, 8'hFF, 8'h01, 8'hFE, 4'b1001, 8});
    vecs.push_back('{4'd13, 8'h0F, 8'h11, 8'hFF, 8'h00, 4'b0100, 8});
    vecs.push_back('{4'd11, 8'hC0, 8'h02, 8'h00, 8'h00, 4'b1010, 2});
    vecs.push_back('{4'd12, 8'h81, 8'h01, 8'hC0, 8'h00, 4'b1100, 1});
    vecs.push_back('{4'd11, 8'h5A, 8'h00, 8'h5A, 8'h00, 4'b1000, 1});
    vecs.push_back('{4'd1,  8'h00, 8'h00, 8'h00, 8'h00, 4'b0010, 1});
    vecs.push_back('{4'd11, 8'h5A, 8'h00, 8'h5A, 8'h00, 4'b0000, 1});
    vecs.push_back('{4'd12, 8'h81, 8'h01, 8'hC0, 8'h00, 4'b1100, 1});
    vecs.push_back('{4'd9,  8'hF0, 8'hFF, 8'h0F, 8'h00, 4'b1000, 1});
    vecs.push_back('{4'd10, 8'h00, 8'h00, 8'hFF, 8'h00, 4'b1100, 1});
    vecs.push_back('{4'd2,  8'hFF, 8'h00, 8'h00, 8'h00, 4'b1010, 1});
    vecs.push_back('{4'd5,  8'h7F, 8'h00, 8'h80, 8'h00, 4'b0101, 1});
    vecs.push_back('{4'd6,  8'h00, 8'h00, 8'hFF, 8'h00, 4'b0100, 1});
    vecs.push_back('{4'd14, 8'h12, 8'h80, 8'h80, 8'h00, 4'b0100, 1});
    vecs.push_back('{4'd0,  8'h12, 8'h34, 8'h00, 8'h00, 4'b0100, 1});
    vecs.push_back('{4'd7,  8'h3C, 8'h0F, 8'h0C, 8'h00, 4'b0000, 1});
    vecs.push_back('{4'd8,  8'h30, 8'h03, 8'h33, 8'h00, 4'b0000, 1});
    vecs.push_back('{4'd12, 8'h01, 8'h03, 8'h20, 8'h00, 4'b0000, 3});
    vecs.push_back('{4'd11, 8'h81, 8'h0F, 8'h80, 8'h00, 4'b0100, 7});

    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; op = '0; a = '0; b = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(in_ready), 1);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_res", 32'({res_hi, res}), 0);
    chk("rst_flags", 32'(flags), 0);
    reset = 1'b0;
    @(posedge clk); #1;

    // ADD 7F+01 with output backpressure and an ignored in_valid pulse
    op = 4'd1; a = 8'h7F; b = 8'h01; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("add_lat0_valid", 32'(out_valid), 0);
    @(posedge clk); #1;
    chk("add_lat1_valid", 32'(out_valid), 1);
    for (int i = 0; i < 5; i++) begin
      if (i == 1) begin op = 4'd10; a = 8'h00; in_valid = 1'b1; end
      else in_valid = 1'b0;
      chk("hold_valid", 32'(out_valid), 1);
      chk("hold_res", 32'(res), 32'h80);
      chk("hold_flags", 32'(flags), 32'b0101);
      chk("hold_in_ready", 32'(in_ready), 0);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("consume_in_ready", 32'(in_ready), 1);
    repeat (2) @(posedge clk);
    #1;
    chk("ignored_pulse_no_result", 32'(out_valid), 0);
    chk("ignored_pulse_idle", 32'(busy), 0);

    foreach (vecs[i]) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, r, rh, f, lat);
      $display("vec %0d op=%0d a=%h b=%h -> res=%h hi=%h flags=%b lat=%0d",
               i, vecs[i].op, vecs[i].a, vecs[i].b, r, rh, f, lat);
      chk($sformatf("vec%0d_res", i), 32'(r), 32'(vecs[i].exp_res));
      chk($sformatf("vec%0d_hi", i), 32'(rh), 32'(vecs[i].exp_hi));
      chk($sformatf("vec%0d_flags", i), 32'(f), 32'(vecs[i].exp_flags));
      chk($sformatf("vec%0d_lat", i), 32'(lat), 32'(vecs[i].exp_lat));
    end

    // Reset three cycles into a MUL
    op = 4'd13; a = 8'hFF; b = 8'hFF; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("mul_mid_busy", 32'(busy), 1);
    reset = 1'b1;
    #1;
    chk("midrst_out_valid", 32'(out_valid), 0);
    chk("midrst_flags", 32'(flags), 0);
    chk("midrst_in_ready", 32'(in_ready), 1);
    chk("midrst_res", 32'({res_hi, res}), 0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    run_op(4'd1, 8'h00, 8'h00, r, rh, f, lat);
    $display("post-reset ADD 00+00 -> res=%h flags=%b", r, f);
    chk("postrst_res", 32'(r), 0);
    chk("postrst_flags", 32'(f), 32'b0010);

    // Back-to-back: in_valid held high over four queued ops
    begin
      logic [3:0] q_op[4]  = '{4'd1, 4'd9, 4'd11, 4'd13};
      logic [7:0] q_a[4]   = '{8'h01, 8'hFF, 8'h01, 8'h03};
      logic [7:0] q_b[4]   = '{8'h02, 8'h0F, 8'h03, 8'h05};
      logic [7:0] q_exp[4] = '{8'h03, 8'hF0, 8'h08, 8'h0F};
      int idx = 0;
      int got = 0;
      out_ready = 1'b1;
      for (int cyc = 0; cyc < 200 && got < 4; cyc++) begin
        if (idx < 4) begin
          in_valid = 1'b1; op = q_op[idx]; a = q_a[idx]; b = q_b[idx];
        end else in_valid = 1'b0;
        @(negedge clk);
        if (in_valid && in_ready) begin
          chk("b2b_accept_idle", 32'(busy), 0);
          idx++;
        end
        if (out_valid) begin
          $display("b2b result %0d res=%h", got, res);
          chk($sformatf("b2b_res%0d", got), 32'(res), 32'(q_exp[got]));
          got++;
        end
        @(posedge clk); #1;
      end
      in_valid = 1'b0;
      out_ready = 1'b0;
      chk("b2b_accepted", 32'(idx), 4);
      chk("b2b_results", 32'(got), 4);
      repeat (3) @(posedge clk);
      #1;
      chk("b2b_no_extra", 32'(out_valid), 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
